gmii_tx_frame_monitor: RTL

//  Passive checker on the registered GMII transmit output (gmii_tx_en/gmii_txd) of the Ethernet top.
//  - Validates preamble/SFD, length, FCS (CRC-32) and inter-frame gap of every frame sent (ARP and UDP).
//  - Reports per-frame status and running counters for ILA/debug and for the simulation scoreboard.
//  - Never drives the GMII bus.

---
 rtl/gmii_tx_frame_monitor_pkg.sv | 37 +++
 rtl/gmii_tx_frame_monitor_if.sv | 10 +
 rtl/gmii_tx_frame_monitor_crc32_d8.sv | 24 ++
 rtl/gmii_tx_frame_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_frame_monitor_pkg.sv
// Shared constants, state encoding and helpers for the GMII transmit frame monitor.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

  // One-hot frame tracking states
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    PREAMBLE = 4'b0010,
    DATA     = 4'b0100,
    DISCARD  = 4'b1000
  } state_t;

  // Bit positions inside err_flags
  localparam int ERR_PRE   = 0;
  localparam int ERR_FCS   = 1;
  localparam int ERR_RUNT  = 2;
  localparam int ERR_GIANT = 3;
  localparam int ERR_IFG   = 4;
  localparam int ERR_W     = 5;

  // The CRC register is kept in reflected (LSB-first) order while the residue
  // constant is written in normal bit order, so the register is reversed
  // before it is compared.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gmii_tx_frame_monitor_if.sv
// GMII transmit bus as seen by a sender (master) and by the passive monitor (slave).
interface gmii_tx_frame_monitor_if;

  logic       gmii_tx_en;
  logic [7:0] gmii_txd;

  modport master (output gmii_tx_en, output gmii_txd);
  modport slave  (input  gmii_tx_en, input  gmii_txd);

endinterface

// File: rtl/gmii_tx_frame_monitor_crc32_d8.sv
// Combinational CRC-32 step for one byte, reflected polynomial, bits taken LSB first.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  // Shift the eight data bits through the reflected LFSR, bit 0 first
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_frame_monitor.sv
// Passive checker of the registered GMII transmit stream: preamble/SFD, length,
// FCS and inter-frame gap per frame, with per-frame status and running counters.
module gmii_tx_frame_monitor
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int IFG_MIN   = 12
) (
  input  logic                  gmii_tx_clk,
  input  logic                  rst,
  gmii_tx_frame_monitor_if.slave gmii,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [15:0]           frame_len,
  output logic [15:0]           ether_type,
  output logic [ERR_W-1:0]      err_flags,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           err_cnt
);

  localparam logic [15:0] IFG_MIN_L = 16'(IFG_MIN);
  localparam logic [15:0] MIN_L     = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_L     = 16'(MAX_FRAME);

  logic       en;
  logic [7:0] txd;

  assign en  = gmii.gmii_tx_en;
  assign txd = gmii.gmii_txd;

  state_t      state, state_next;
  logic [15:0] ifg_cnt, ifg_next;
  logic        ifg_short, ifg_short_next;
  logic [2:0]  pre_cnt, pre_cnt_next;
  logic [31:0] crc, crc_next, crc_calc;
  logic [15:0] len, len_next;
  logic [15:0] et_work, et_next;
  logic        silent, silent_next;
  logic        just_reset;

  logic             end_frame;
  logic [ERR_W-1:0] flags_end;
  logic [15:0]      len_end;
  logic [15:0]      et_end;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (txd),
    .crc_out (crc_calc)
  );

  // Next-state and frame-end evaluation for the frame tracker
  always_comb begin
    state_next     = state;
    ifg_next       = ifg_cnt;
    ifg_short_next = ifg_short;
    pre_cnt_next   = pre_cnt;
    crc_next       = crc;
    len_next       = len;
    et_next        = et_work;
    silent_next    = silent;
    end_frame      = 1'b0;
    flags_end      = '0;
    len_end        = 16'h0000;
    et_end         = 16'h0000;

    unique case (state)
      IDLE: begin
        if (!en) begin
          if (ifg_cnt < IFG_MIN_L) begin
            ifg_next = ifg_cnt + 16'd1;
          end
        end else begin
          ifg_short_next = (ifg_cnt < IFG_MIN_L);
          pre_cnt_next   = 3'd0;
          len_next       = 16'h0000;
          et_next        = 16'h0000;
          silent_next    = 1'b0;
          // A frame already in flight when reset released is not ours to judge
          if (just_reset) begin
            state_next  = DISCARD;
            silent_next = 1'b1;
          end else if (txd == PREAMBLE_BYTE) begin
            state_next   = PREAMBLE;
            pre_cnt_next = 3'd1;
          end else begin
            state_next = DISCARD;
          end
        end
      end

      PREAMBLE: begin
        if (!en) begin
          end_frame          = 1'b1;
          flags_end[ERR_PRE] = 1'b1;
        end else if (txd == PREAMBLE_BYTE && pre_cnt < 3'd7) begin
          pre_cnt_next = pre_cnt + 3'd1;
        end else if (txd == SFD_BYTE && pre_cnt == 3'd7) begin
          state_next = DATA;
          crc_next   = CRC32_INIT;
          len_next   = 16'h0000;
        end else begin
          state_next = DISCARD;
        end
      end

      DATA: begin
        if (!en) begin
          end_frame            = 1'b1;
          flags_end[ERR_FCS]   = (bit_reverse32(crc) != CRC32_RESIDUE);
          flags_end[ERR_RUNT]  = (len < MIN_L);
          flags_end[ERR_GIANT] = (len > MAX_L);
          len_end              = len;
          et_end               = (len >= 16'd14) ? et_work : 16'h0000;
        end else begin
          crc_next = crc_calc;
          if (len != 16'hFFFF) begin
            len_next = len + 16'd1;
          end
          if (len == 16'd12) begin
            et_next[15:8] = txd;
          end
          if (len == 16'd13) begin
            et_next[7:0] = txd;
          end
        end
      end

      DISCARD: begin
        if (!en) begin
          if (silent) begin
            state_next  = IDLE;
            ifg_next    = IFG_MIN_L;
            silent_next = 1'b0;
          end else begin
            end_frame          = 1'b1;
            flags_end[ERR_PRE] = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The cycle that samples en low already counts as the first idle cycle
    if (end_frame) begin
      state_next         = IDLE;
      ifg_next           = 16'd1;
      flags_end[ERR_IFG] = ifg_short;
    end
  end

  // Frame tracker registers
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state      <= IDLE;
      ifg_cnt    <= IFG_MIN_L;
      ifg_short  <= 1'b0;
      pre_cnt    <= 3'd0;
      crc        <= CRC32_INIT;
      len        <= 16'h0000;
      et_work    <= 16'h0000;
      silent     <= 1'b0;
      just_reset <= 1'b1;
    end else begin
      state      <= state_next;
      ifg_cnt    <= ifg_next;
      ifg_short  <= ifg_short_next;
      pre_cnt    <= pre_cnt_next;
      crc        <= crc_next;
      len        <= len_next;
      et_work    <= et_next;
      silent     <= silent_next;
      just_reset <= 1'b0;
    end
  end

  // Status outputs and saturating counters, refreshed once per completed frame
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= 16'h0000;
      ether_type <= 16'h0000;
      err_flags  <= '0;
      frame_cnt  <= 32'h0000_0000;
      err_cnt    <= 32'h0000_0000;
    end else begin
      frame_done <= end_frame;
      if (end_frame) begin
        frame_ok   <= (flags_end == '0);
        frame_len  <= len_end;
        ether_type <= et_end;
        err_flags  <= flags_end;
        if (frame_cnt != 32'hFFFF_FFFF) begin
          frame_cnt <= frame_cnt + 32'd1;
        end
        if (flags_end != '0 && err_cnt != 32'hFFFF_FFFF) begin
          err_cnt <= err_cnt + 32'd1;
        end
      end
    end
  end

endmodule
